// File: rtl/fir_coeff_sched.sv
// Sample-strobe / accumulate-enable generator and double-buffered coefficient bank
// for a chain of 3-tap transposed-FIR stages; swaps land atomically on a sample boundary.
module fir_coeff_sched #(
   parameter int NUM_STAGE = 4,
   parameter int DIV       = 40,
   parameter int COEFF_W   = 16
) (
   input  logic                             iClk_12M,
   input  logic                             iRsn,
   input  logic                             iRun,
   input  logic                             iCoeffWr,
   input  logic [3:0]                       iCoeffAddr,
   input  logic [COEFF_W-1:0]               iCoeffData,
   input  logic                             iCoeffUpdate,
   output logic                             oEnSample_300k,
   output logic                             oEnAcc,
   output logic [NUM_STAGE*3*COEFF_W-1:0]   oCoeff,
   output logic                             oPending,
   output logic                             oCoeffAck,
   output logic                             oWrErr
);

   localparam int                 NUM_W    = NUM_STAGE * 3;
   localparam int                 CNT_W    = $clog2(DIV);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [4:0]         ADDR_LIM = 5'(NUM_W);

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   state_t                          state_r;
   state_t                          state_s;
   logic [CNT_W-1:0]                cnt_r;
   logic [NUM_W-1:0][COEFF_W-1:0]   shadow_r;
   logic [NUM_W-1:0][COEFF_W-1:0]   active_r;
   logic                            strobe_s;
   logic                            addr_ok_s;
   logic                            wr_ok_s;
   logic                            wr_err_s;
   logic                            swap_s;
   logic                            acc_r;
   logic                            ack_r;
   logic                            err_r;

   assign strobe_s  = iRun & (cnt_r == CNT_LAST);
   assign addr_ok_s = ({1'b0, iCoeffAddr} < ADDR_LIM);

   // Sample period counter; held at zero while timing is stopped.
   always_ff @(posedge iClk_12M or negedge iRsn) begin
      if (!iRsn) begin
         cnt_r <= '0;
      end else if (!iRun) begin
         cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   // Swap FSM state register.
   always_ff @(posedge iClk_12M or negedge iRsn) begin
      if (!iRsn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state, write acceptance and swap decision.
   always_comb begin
      state_s  = state_r;
      wr_ok_s  = 1'b0;
      wr_err_s = 1'b0;
      swap_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // A strobe in the same cycle as the request is too early to swap on.
            if (iCoeffUpdate) begin
               state_s = ST_PENDING;
            end else begin
               state_s = ST_IDLE;
            end
            wr_ok_s  = iCoeffWr & addr_ok_s;
            wr_err_s = iCoeffWr & ~addr_ok_s;
         end
         ST_PENDING: begin
            if (strobe_s) begin
               state_s = ST_IDLE;
               swap_s  = 1'b1;
            end else begin
               state_s = ST_PENDING;
            end
            wr_err_s = iCoeffWr;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Coefficient banks and registered pulse outputs.
   always_ff @(posedge iClk_12M or negedge iRsn) begin
      if (!iRsn) begin
         shadow_r <= '0;
         active_r <= '0;
         acc_r    <= 1'b0;
         ack_r    <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         if (wr_ok_s) begin
            shadow_r[iCoeffAddr] <= iCoeffData;
         end
         if (swap_s) begin
            active_r <= shadow_r;
         end
         acc_r <= strobe_s;
         ack_r <= swap_s;
         err_r <= wr_err_s;
      end
   end

   assign oEnSample_300k = strobe_s;
   assign oEnAcc         = acc_r;
   assign oCoeff         = active_r;
   assign oPending       = (state_r == ST_PENDING);
   assign oCoeffAck      = ack_r;
   assign oWrErr         = err_r;

endmodule

// File: tb/tb_fir_coeff_sched.sv
// Scoreboard bench for fir_coeff_sched: stimulus queues expected pulses and levels,
// a negedge monitor pops and compares them as the DUT produces outputs.
module tb_fir_coeff_sched;

   localparam int CW = 16;
   localparam int NW = 12;
   localparam int VW = NW * CW;

   logic           iClk_12M     = 1'b0;
   logic           iRsn         = 1'b0;
   logic           iRun         = 1'b0;
   logic           iCoeffWr     = 1'b0;
   logic [3:0]     iCoeffAddr   = 4'd0;
   logic [CW-1:0]  iCoeffData   = 16'd0;
   logic           iCoeffUpdate = 1'b0;
   logic           oEnSample_300k;
   logic           oEnAcc;
   logic [VW-1:0]  oCoeff;
   logic           oPending;
   logic           oCoeffAck;
   logic           oWrErr;

   fir_coeff_sched #(.NUM_STAGE(4), .DIV(40), .COEFF_W(CW)) dut (
      .iClk_12M       (iClk_12M),
      .iRsn           (iRsn),
      .iRun           (iRun),
      .iCoeffWr       (iCoeffWr),
      .iCoeffAddr     (iCoeffAddr),
      .iCoeffData     (iCoeffData),
      .iCoeffUpdate   (iCoeffUpdate),
      .oEnSample_300k (oEnSample_300k),
      .oEnAcc         (oEnAcc),
      .oCoeff         (oCoeff),
      .oPending       (oPending),
      .oCoeffAck      (oCoeffAck),
      .oWrErr         (oWrErr)
   );

   always #5 iClk_12M = ~iClk_12M;

   typedef struct {
      int            cyc;
      int            kind;
      logic [VW-1:0] val;
   } exp_t;

   int   q_smp[$];
   int   q_acc[$];
   int   q_err[$];
   exp_t q_ack[$];
   exp_t q_lvl[$];
   int   edges    = 0;
   int   rel_edge = 0;
   int   n_cmp    = 0;
   int   n_bad    = 0;

   always @(posedge iClk_12M) edges <= edges + 1;

   task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic unexpected(input string nm, input int c);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: pulse at cycle %0d, none expected", nm, c);
   endtask

   task automatic missing(input string nm, input int c);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: expected at cycle %0d, never seen", nm, c);
   endtask

   // Monitor: compare every output pulse and every scheduled level check.
   always @(negedge iClk_12M) begin
      int   c;
      exp_t e;
      c = edges - rel_edge;
      if (oEnSample_300k) begin
         if (q_smp.size() == 0) unexpected("strobe", c);
         else chk("strobe_cycle", VW'(c), VW'(q_smp.pop_front()));
      end
      if (oEnAcc) begin
         if (q_acc.size() == 0) unexpected("en_acc", c);
         else chk("en_acc_cycle", VW'(c), VW'(q_acc.pop_front()));
      end
      if (oWrErr) begin
         if (q_err.size() == 0) unexpected("wr_err", c);
         else chk("wr_err_cycle", VW'(c), VW'(q_err.pop_front()));
      end
      if (oCoeffAck) begin
         if (q_ack.size() == 0) unexpected("coeff_ack", c);
         else begin
            e = q_ack.pop_front();
            chk("ack_cycle", VW'(c), VW'(e.cyc));
            chk("ack_coeff", oCoeff, e.val);
         end
      end
      while (q_lvl.size() > 0 && q_lvl[0].cyc <= c) begin
         e = q_lvl.pop_front();
         if (e.kind == 0) chk("pending", VW'(oPending), e.val);
         else chk("coeff", oCoeff, e.val);
      end
   end

   task automatic goto(input int c);
      while (edges - rel_edge < c) begin
         @(posedge iClk_12M);
         #1;
      end
   endtask

   task automatic lvl(input int c, input int k, input logic [VW-1:0] v);
      q_lvl.push_back('{c, k, v});
   endtask

   task automatic ack(input int c, input logic [VW-1:0] v);
      q_ack.push_back('{c, 0, v});
   endtask

   task automatic leftovers();
      foreach (q_smp[i]) missing("strobe", q_smp[i]);
      foreach (q_acc[i]) missing("en_acc", q_acc[i]);
      foreach (q_err[i]) missing("wr_err", q_err[i]);
      foreach (q_ack[i]) missing("coeff_ack", q_ack[i].cyc);
      foreach (q_lvl[i]) missing("level", q_lvl[i].cyc);
      q_smp.delete();
      q_acc.delete();
      q_err.delete();
      q_ack.delete();
      q_lvl.delete();
   endtask

   // Cycle 0 of the new epoch is the cycle in which reset is released.
   task automatic do_reset(input logic run);
      iRsn         = 1'b0;
      iRun         = 1'b0;
      iCoeffWr     = 1'b0;
      iCoeffUpdate = 1'b0;
      iCoeffAddr   = 4'd0;
      iCoeffData   = 16'd0;
      repeat (3) begin
         @(posedge iClk_12M);
         #1;
      end
      leftovers();
      iRun     = run;
      iRsn     = 1'b1;
      rel_edge = edges;
   endtask

   task automatic wr(input int c, input int k, input logic [CW-1:0] d, input logic upd);
      goto(c);
      iCoeffWr     = 1'b1;
      iCoeffAddr   = 4'(k);
      iCoeffData   = d;
      iCoeffUpdate = upd;
      goto(c + 1);
      iCoeffWr     = 1'b0;
      iCoeffUpdate = 1'b0;
   endtask

   task automatic upd(input int c);
      goto(c);
      iCoeffUpdate = 1'b1;
      goto(c + 1);
      iCoeffUpdate = 1'b0;
   endtask

   initial begin
      logic [VW-1:0] v;

      // Reset and strobe cadence.
      do_reset(1'b1);
      q_smp.push_back(39); q_smp.push_back(79); q_smp.push_back(119);
      q_acc.push_back(40); q_acc.push_back(80); q_acc.push_back(120);
      lvl(5, 0, '0);
      lvl(38, 1, '0);
      lvl(38, 0, '0);
      goto(125);

      // Full bank load, update together with the last write.
      do_reset(1'b1);
      v = '0;
      for (int k = 0; k < NW; k++) v[k*CW +: CW] = 16'(16'h0101 * (k + 1));
      q_smp.push_back(39);
      q_acc.push_back(40);
      lvl(11, 0, '0);
      lvl(12, 0, VW'(1));
      lvl(39, 0, VW'(1));
      lvl(39, 1, '0);
      lvl(40, 1, v);
      lvl(40, 0, '0);
      ack(40, v);
      for (int k = 0; k < NW; k++) wr(k, k, 16'(16'h0101 * (k + 1)), (k == NW - 1));
      goto(45);

      // Update collides with the strobe: swap deferred to the next sample.
      do_reset(1'b1);
      v = '0;
      v[0 +: CW] = 16'h1234;
      q_smp.push_back(39); q_smp.push_back(79);
      q_acc.push_back(40); q_acc.push_back(80);
      lvl(39, 0, '0);
      lvl(40, 0, VW'(1));
      lvl(40, 1, '0);
      lvl(79, 0, VW'(1));
      lvl(79, 1, '0);
      ack(80, v);
      wr(5, 0, 16'h1234, 1'b0);
      upd(39);
      goto(85);

      // Rejected writes: during PENDING and to an out-of-range address.
      do_reset(1'b1);
      v = '0;
      v[3*CW +: CW] = 16'h0303;
      q_smp.push_back(39); q_smp.push_back(79);
      q_acc.push_back(40); q_acc.push_back(80);
      q_err.push_back(8); q_err.push_back(10); q_err.push_back(46);
      lvl(8, 0, VW'(1));
      ack(40, v);
      ack(80, v);
      wr(2, 3, 16'h0303, 1'b0);
      upd(5);
      wr(7, 3, 16'hBEEF, 1'b0);
      wr(9, 12, 16'hDEAD, 1'b0);
      wr(45, 12, 16'hDEAD, 1'b0);
      upd(47);
      goto(85);

      // Timing stopped while a swap is pending.
      do_reset(1'b1);
      v = '0;
      v[1*CW +: CW] = 16'h00AA;
      q_smp.push_back(149);
      q_acc.push_back(150);
      lvl(50, 0, VW'(1));
      lvl(109, 0, VW'(1));
      lvl(149, 0, VW'(1));
      lvl(149, 1, '0);
      lvl(150, 0, '0);
      ack(150, v);
      wr(2, 1, 16'h00AA, 1'b0);
      upd(3);
      goto(10);
      iRun = 1'b0;
      goto(110);
      iRun = 1'b1;
      goto(155);

      // Reset while pending discards the swap.
      do_reset(1'b1);
      wr(1, 2, 16'h7777, 1'b0);
      upd(2);
      lvl(20, 0, '0);
      lvl(20, 1, '0);
      goto(20);
      iRsn = 1'b0;
      goto(25);
      iRsn     = 1'b1;
      rel_edge = edges;
      q_smp.push_back(39);
      q_acc.push_back(40);
      lvl(40, 0, '0);
      lvl(40, 1, '0);
      goto(45);

      leftovers();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
